// File: rtl/br_resolve_ctrl_pkg.sv
// Shared types and constants for the branch-resolution controller.
// The opcode constants classify what the ID-stage detector flagged.
package br_resolve_ctrl_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_FLUSH   = 2'd2
    } state_e;

    typedef enum logic {
        KIND_CTRL  = 1'b0,
        KIND_AUIPC = 1'b1
    } kind_e;

    // AUIPC never redirects, so it resolves like a not-taken branch.
    // Any other opcode reaching here was already qualified by the detector.
    function automatic kind_e classify(input logic [6:0] opcode);
        kind_e kind;
        case (opcode)
            OPC_JAL, OPC_JALR, OPC_BRANCH: kind = KIND_CTRL;
            OPC_AUIPC:                     kind = KIND_AUIPC;
            default:                       kind = KIND_CTRL;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/br_resolve_ctrl_sat_counter16.sv
// 16-bit event counter that increments on en_i and sticks at all-ones.
module sat_counter16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    output logic [15:0] count_o
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/br_resolve_ctrl.sv
// Tracks one detected control-transfer instruction from ID until EX resolves it,
// then issues a redirect pulse and a multi-cycle pipeline flush when taken.
module br_resolve_ctrl
    import br_resolve_ctrl_pkg::*;
#(
    parameter int XLEN         = XLEN_DEFAULT,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic            id_br_detect,
    input  logic [6:0]      id_opcode,
    input  logic [XLEN-1:0] id_pc,
    input  logic            stall_in,
    input  logic            ex_valid,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    output logic            busy,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic [15:0]     br_count,
    output logic [15:0]     redir_count
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_e          state_q, state_d;
    kind_e           kind_q, kind_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic [3:0]      flush_cnt_q, flush_cnt_d;
    logic            busy_q, busy_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic            flush_q, flush_d;
    logic            id_take;
    logic            accept;
    logic            redirect;

    assign id_take = id_valid & id_br_detect & ~stall_in;

    always_comb begin
        state_d          = state_q;
        kind_d           = kind_q;
        pc_d             = pc_q;
        redirect_pc_d    = redirect_pc_q;
        flush_cnt_d      = flush_cnt_q;
        redirect_valid_d = 1'b0;
        flush_d          = 1'b0;
        accept           = 1'b0;
        redirect         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                accept = id_take;
            end
            ST_RESOLVE: begin
                if (ex_valid && !stall_in) begin
                    if (ex_taken && (kind_q == KIND_CTRL)) begin
                        redirect         = 1'b1;
                        redirect_valid_d = 1'b1;
                        redirect_pc_d    = ex_target;
                        flush_d          = 1'b1;
                        flush_cnt_d      = FLUSH_LOAD;
                        state_d          = ST_FLUSH;
                    end else begin
                        state_d = ST_IDLE;
                        accept  = id_take;
                    end
                end
            end
            ST_FLUSH: begin
                // The counter holds the number of flush cycles still to come.
                if (flush_cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                    flush_d     = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            state_d = ST_RESOLVE;
            kind_d  = classify(id_opcode);
            pc_d    = id_pc;
        end
    end

    assign busy_d = (state_d != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            kind_q           <= KIND_CTRL;
            pc_q             <= '0;
            redirect_pc_q    <= '0;
            flush_cnt_q      <= '0;
            busy_q           <= 1'b0;
            redirect_valid_q <= 1'b0;
            flush_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            kind_q           <= kind_d;
            pc_q             <= pc_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_cnt_q      <= flush_cnt_d;
            busy_q           <= busy_d;
            redirect_valid_q <= redirect_valid_d;
            flush_q          <= flush_d;
        end
    end

    sat_counter16 u_br_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (accept),
        .count_o (br_count)
    );

    sat_counter16 u_redir_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (redirect),
        .count_o (redir_count)
    );

    assign busy           = busy_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = flush_q;

endmodule

// File: tb/tb_br_resolve_ctrl.sv
// Bench for br_resolve_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against an abstract model.
module tb_br_resolve_ctrl;

    localparam int XLEN = 32;
    localparam int FC   = 2;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            id_valid = 1'b0;
    logic            id_br_detect = 1'b0;
    logic [6:0]      id_opcode = '0;
    logic [XLEN-1:0] id_pc = '0;
    logic            stall_in = 1'b0;
    logic            ex_valid = 1'b0;
    logic            ex_taken = 1'b0;
    logic [XLEN-1:0] ex_target = '0;
    logic            busy;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            flush;
    logic [15:0]     br_count;
    logic [15:0]     redir_count;

    int checks = 0;
    int errors = 0;

    br_resolve_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .id_br_detect   (id_br_detect),
        .id_opcode      (id_opcode),
        .id_pc          (id_pc),
        .stall_in       (stall_in),
        .ex_valid       (ex_valid),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .busy           (busy),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .br_count       (br_count),
        .redir_count    (redir_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Abstract model: an instruction is either pending resolution, or a flush
    // window of FC cycles is counting down; counts are plain event tallies.
    int              m_flush_left = 0;
    bit              m_inflight = 1'b0;
    bit              m_auipc = 1'b0;
    bit              m_redir = 1'b0;
    logic [XLEN-1:0] m_rpc = '0;
    int              m_br = 0;
    int              m_rc = 0;
    int              br_bias = 0;
    int              rc_bias = 0;

    function automatic int sat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit can_take;
        bit fired;
        if (!rst_n) begin
            m_flush_left = 0;
            m_inflight   = 1'b0;
            m_auipc      = 1'b0;
            m_redir      = 1'b0;
            m_rpc        = '0;
            m_br         = 0;
            m_rc         = 0;
        end else begin
            can_take = 1'b0;
            fired    = 1'b0;
            if (m_flush_left > 0) begin
                m_flush_left = m_flush_left - 1;
            end else if (!m_inflight) begin
                can_take = 1'b1;
            end else if (ex_valid && !stall_in) begin
                m_inflight = 1'b0;
                if (ex_taken && !m_auipc) begin
                    fired        = 1'b1;
                    m_flush_left = FC;
                    m_rpc        = ex_target;
                    m_rc         = m_rc + 1;
                end else begin
                    can_take = 1'b1;
                end
            end
            if (can_take && id_valid && id_br_detect && !stall_in) begin
                m_inflight = 1'b1;
                m_auipc    = (id_opcode == OP_AUIPC);
                m_br       = m_br + 1;
            end
            m_redir = fired;
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_inflight || (m_flush_left > 0)));
        chk("flush", 32'(flush), 32'(m_flush_left > 0));
        chk("redirect_valid", 32'(redirect_valid), 32'(m_redir));
        chk("redirect_pc", redirect_pc, m_rpc);
        chk("br_count", 32'(br_count), sat(m_br + br_bias));
        chk("redir_count", 32'(redir_count), sat(m_rc + rc_bias));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        id_valid     = 1'b0;
        id_br_detect = 1'b0;
        stall_in     = 1'b0;
        ex_valid     = 1'b0;
        ex_taken     = 1'b0;
    endtask

    task automatic present(input logic [6:0] op, input logic [XLEN-1:0] pc);
        id_valid     = 1'b1;
        id_br_detect = 1'b1;
        id_opcode    = op;
        id_pc        = pc;
    endtask

    task automatic resolve(input logic taken, input logic [XLEN-1:0] tgt);
        ex_valid  = 1'b1;
        ex_taken  = taken;
        ex_target = tgt;
    endtask

    initial begin
        #7;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_rv", 32'(redirect_valid), 0);
        chk("rst_rpc", redirect_pc, 0);
        chk("rst_cnt", {br_count, redir_count}, 0);
        #5 rst_n = 1'b1;

        // Taken JAL: accept, resolve, one redirect pulse, two flush cycles.
        present(OP_JAL, 32'h100); tick();
        chk("jal_busy", 32'(busy), 1);
        chk("jal_br", 32'(br_count), 1);
        idle_in(); resolve(1'b1, 32'h200); tick();
        chk("jal_rv", 32'(redirect_valid), 1);
        chk("jal_rpc", redirect_pc, 32'h200);
        chk("jal_flush1", 32'(flush), 1);
        chk("jal_redir", 32'(redir_count), 1);
        idle_in(); tick();
        chk("jal_rv_drop", 32'(redirect_valid), 0);
        chk("jal_flush2", 32'(flush), 1);
        chk("jal_rpc_hold", redirect_pc, 32'h200);
        tick();
        chk("jal_flush_end", 32'(flush), 0);
        chk("jal_idle", 32'(busy), 0);

        // Not-taken BEQ with BNE accepted in the same resolving cycle.
        present(OP_BR, 32'h300); tick();
        resolve(1'b0, 32'h999); present(OP_BR, 32'h304); tick();
        chk("b2b_busy", 32'(busy), 1);
        chk("b2b_flush", 32'(flush), 0);
        chk("b2b_rv", 32'(redirect_valid), 0);
        chk("b2b_br", 32'(br_count), 3);
        chk("b2b_redir", 32'(redir_count), 1);
        idle_in(); resolve(1'b0, 32'h0); tick();
        chk("b2b_done", 32'(busy), 0);

        // AUIPC with ex_taken set must not redirect.
        idle_in(); present(OP_AUIPC, 32'h500); tick();
        idle_in(); resolve(1'b1, 32'h600); tick();
        chk("auipc_busy", 32'(busy), 0);
        chk("auipc_rv", 32'(redirect_valid), 0);
        chk("auipc_flush", 32'(flush), 0);
        chk("auipc_redir", 32'(redir_count), 1);

        // Stall holds RESOLVE; redirect follows the release edge.
        idle_in(); present(OP_JALR, 32'h700); tick();
        idle_in(); resolve(1'b1, 32'h400); stall_in = 1'b1;
        repeat (3) begin
            tick();
            chk("stall_busy", 32'(busy), 1);
            chk("stall_rv", 32'(redirect_valid), 0);
        end
        stall_in = 1'b0; tick();
        chk("stall_rel_rv", 32'(redirect_valid), 1);
        chk("stall_rel_rpc", redirect_pc, 32'h400);
        idle_in(); tick(); tick();
        chk("stall_idle", 32'(busy), 0);

        // Detect without valid, and detect while stalled, are both ignored.
        id_br_detect = 1'b1; tick();
        chk("novalid_busy", 32'(busy), 0);
        id_valid = 1'b1; stall_in = 1'b1; tick();
        chk("stall_idle_busy", 32'(busy), 0);
        chk("ignored_br", 32'(br_count), 5);

        // Async reset during the first flush cycle.
        idle_in(); present(OP_JAL, 32'h800); tick();
        idle_in(); resolve(1'b1, 32'h900); tick();
        chk("pre_rst_flush", 32'(flush), 1);
        idle_in(); rst_n = 1'b0; #1;
        chk("rst_flush_drop", 32'(flush), 0);
        chk("rst_busy_drop", 32'(busy), 0);
        chk("rst_rv_drop", 32'(redirect_valid), 0);
        chk("rst_cnt_clr", {br_count, redir_count}, 0);
        present(OP_JAL, 32'hA00); #2 rst_n = 1'b1;
        tick();
        chk("first_edge_accept", 32'(busy), 1);
        chk("first_edge_br", 32'(br_count), 1);
        chk("post_rst_rv", 32'(redirect_valid), 0);
        idle_in(); resolve(1'b0, 32'h0); tick();
        chk("post_rst_redir", 32'(redir_count), 0);

        // Saturation: preload both counters one below the limit.
        idle_in(); tick();
        force dut.u_br_cnt.count_q = 16'hFFFE;
        force dut.u_redir_cnt.count_q = 16'hFFFE;
        br_bias = 65534 - m_br;
        rc_bias = 65534 - m_rc;
        #1;
        release dut.u_br_cnt.count_q;
        release dut.u_redir_cnt.count_q;
        repeat (2) begin
            present(OP_JAL, 32'hB00); tick();
            idle_in(); resolve(1'b1, 32'h1000); tick();
            chk("sat_br", 32'(br_count), 32'hFFFF);
            chk("sat_redir", 32'(redir_count), 32'hFFFF);
            idle_in(); tick(); tick();
        end

        rst_n = 1'b0; br_bias = 0; rc_bias = 0; #2 rst_n = 1'b1;

        repeat (3000) begin
            id_valid     = ($urandom_range(0, 3) != 0);
            id_br_detect = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 4))
                0:       id_opcode = OP_JAL;
                1:       id_opcode = OP_JALR;
                2:       id_opcode = OP_BR;
                3:       id_opcode = OP_AUIPC;
                default: id_opcode = 7'($urandom);
            endcase
            id_pc     = $urandom;
            stall_in  = ($urandom_range(0, 3) == 0);
            ex_valid  = ($urandom_range(0, 1) == 1);
            ex_taken  = ($urandom_range(0, 1) == 1);
            ex_target = $urandom;
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            tick();
        end

        idle_in(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
